// File: rtl/decode_queue_if.sv
// Fetch-to-decode handshake bundle: instruction offer on the in side, decoded head entry on the out side.
// The queue itself uses the slave modport; the fetch/execute environment uses master.
interface decode_queue_if #(
    parameter int unsigned PC_W = 64,
    parameter int unsigned ILEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [PC_W-1:0] in_pc;
    logic [ILEN-1:0] in_instr;

    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [ILEN-1:0] out_instr;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [11:0]     out_csr_addr;
    logic            out_use_rs1;
    logic            out_use_rs2;
    logic            out_wen;

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_rs1, out_rs2, out_rd,
               out_csr_addr, out_use_rs1, out_use_rs2, out_wen
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_rs1, out_rs2, out_rd,
               out_csr_addr, out_use_rs1, out_use_rs2, out_wen
    );
endinterface

// File: rtl/decode_queue.sv
// Circular instruction buffer between fetch and execute; register operands and
// write-enable are decoded when an instruction is pushed and stored with the entry.
module decode_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_W  = 64,
    parameter int unsigned ILEN  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    decode_queue_if.slave                bus,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP32   = 7'b0111011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [ILEN-1:0] instr;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            use_rs1;
        logic            use_rs2;
        logic            wen;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          push_c;
    logic          pop_c;
    entry_t        head_entry_c;
    entry_t        push_entry_c;

    // Operand usage classes by opcode; x0 as destination never writes.
    function automatic entry_t decode(input logic [PC_W-1:0] pc, input logic [ILEN-1:0] instr);
        entry_t     e;
        logic [2:0] funct3;
        logic       use_rs1;
        logic       use_rs2;
        logic       wen;
        funct3  = instr[14:12];
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        wen     = 1'b0;
        case (instr[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                wen = 1'b1;
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_OPIMM32: begin
                use_rs1 = 1'b1;
                wen     = 1'b1;
            end
            OPC_OP, OPC_OP32: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                wen     = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_SYSTEM: begin
                use_rs1 = !funct3[2] && (funct3 != 3'd0);
                wen     = (funct3 != 3'd0);
            end
            default: begin
                use_rs1 = 1'b0;
                use_rs2 = 1'b0;
                wen     = 1'b0;
            end
        endcase
        e.pc      = pc;
        e.instr   = instr;
        e.rd      = instr[11:7];
        e.rs1     = use_rs1 ? instr[19:15] : 5'd0;
        e.rs2     = use_rs2 ? instr[24:20] : 5'd0;
        e.use_rs1 = use_rs1;
        e.use_rs2 = use_rs2;
        e.wen     = wen && (instr[11:7] != 5'd0);
        return e;
    endfunction

    // Handshake qualification; a full queue refuses pushes even while popping.
    always_comb begin
        bus.in_ready  = (count != CW'(DEPTH));
        bus.out_valid = (count != CW'(0));
        push_c        = bus.in_valid && bus.in_ready && !flush;
        pop_c         = bus.out_valid && bus.out_ready && !flush;
        push_entry_c  = decode(bus.in_pc, bus.in_instr);
    end

    // Pointer and occupancy state; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_c) begin
                tail <= tail + PW'(1);
            end
            if (pop_c) begin
                head <= head + PW'(1);
            end
            count <= count + CW'(push_c) - CW'(pop_c);
        end
    end

    // Payload storage carries no reset; validity comes from count alone.
    always_ff @(posedge clk) begin
        if (push_c && !reset) begin
            mem[tail] <= push_entry_c;
        end
    end

    always_comb begin
        head_entry_c     = mem[head];
        bus.out_pc       = head_entry_c.pc;
        bus.out_instr    = head_entry_c.instr;
        bus.out_rs1      = head_entry_c.rs1;
        bus.out_rs2      = head_entry_c.rs2;
        bus.out_rd       = head_entry_c.rd;
        bus.out_csr_addr = head_entry_c.instr[31:20];
        bus.out_use_rs1  = head_entry_c.use_rs1;
        bus.out_use_rs2  = head_entry_c.use_rs2;
        bus.out_wen      = head_entry_c.wen;
    end
endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_decode_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PC_W  = 64;
    localparam int unsigned ILEN  = 32;

    logic       clk;
    logic       reset;
    logic       flush;
    logic [2:0] count;

    decode_queue_if #(.PC_W(PC_W), .ILEN(ILEN)) bus ();

    decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .ILEN(ILEN)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } mentry_t;

    mentry_t     mq[$];
    logic [63:0] pop_log[$];
    int          checks   = 0;
    int          failures = 0;
    bit          cmp_en   = 0;
    bit          log_en   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {rs1, rs2, rd, csr_addr, use_rs1, use_rs2, wen} from the ISA operand rules.
    function automatic logic [29:0] exp_dec(input logic [31:0] ins);
        logic [6:0] op;
        logic [2:0] f3;
        logic       r1, r2, w;
        op = ins[6:0];
        f3 = ins[14:12];
        {r1, r2, w} = 3'b000;
        if (op inside {7'h37, 7'h17, 7'h6F})               {r1, r2, w} = 3'b001;
        else if (op inside {7'h67, 7'h03, 7'h13, 7'h1B})   {r1, r2, w} = 3'b101;
        else if (op inside {7'h33, 7'h3B})                 {r1, r2, w} = 3'b111;
        else if (op inside {7'h23, 7'h63})                 {r1, r2, w} = 3'b110;
        else if (op == 7'h73) begin
            r1 = (f3 >= 3'd1) && (f3 <= 3'd3);
            w  = (f3 != 3'd0);
        end
        if (ins[11:7] == 5'd0) w = 1'b0;
        return {(r1 ? ins[19:15] : 5'd0), (r2 ? ins[24:20] : 5'd0), ins[11:7], ins[31:20], r1, r2, w};
    endfunction

    // Reference model: sizes taken before the edge decide push/pop acceptance.
    always @(posedge clk) begin
        bit p_ok, o_ok;
        if (log_en && !reset && !flush && bus.out_valid && bus.out_ready)
            pop_log.push_back(bus.out_pc);
        if (reset || flush) begin
            mq.delete();
        end else begin
            p_ok = bus.in_valid && (mq.size() < DEPTH);
            o_ok = bus.out_ready && (mq.size() > 0);
            if (o_ok) void'(mq.pop_front());
            if (p_ok) mq.push_back('{pc: bus.in_pc, instr: bus.in_instr});
        end
    end

    // Every-cycle comparison of DUT against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_count", 64'(count), 64'(mq.size()));
            chk("cyc_in_ready", 64'(bus.in_ready), 64'(mq.size() != DEPTH));
            chk("cyc_out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("cyc_pc", bus.out_pc, mq[0].pc);
                chk("cyc_instr", 64'(bus.out_instr), 64'(mq[0].instr));
                chk("cyc_dec", 64'({bus.out_rs1, bus.out_rs2, bus.out_rd, bus.out_csr_addr,
                                    bus.out_use_rs1, bus.out_use_rs2, bus.out_wen}),
                    64'(exp_dec(mq[0].instr)));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins, input logic rdy);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = ins;
        bus.out_ready = rdy;
    endtask

    logic [31:0] tbl [8];

    initial begin
        int pushed;
        int cyc;
        bit accepted;
        tbl[0] = 32'h00B50533; tbl[1] = 32'h00A5A023; tbl[2] = 32'h00000013; tbl[3] = 32'h300022F3;
        tbl[4] = 32'h000010B7; tbl[5] = 32'h00008067; tbl[6] = 32'h00209463; tbl[7] = 32'hFFFFFFFF;

        reset = 1'b1;
        flush = 1'b0;
        drive(1'b0, 64'h0, 32'h0, 1'b0);
        step();
        step();
        reset = 1'b0;
        cmp_en = 1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);

        // Fill to capacity, then a fifth push must be refused.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h80000000 + 64'(4 * i), 32'h00000013, 1'b0);
            step();
        end
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_in_ready", 64'(bus.in_ready), 64'd0);
        chk("fill_head_pc", bus.out_pc, 64'h80000000);
        drive(1'b1, 64'h80000010, 32'h00000013, 1'b0);
        step();
        chk("fifth_count", 64'(count), 64'd4);
        chk("fifth_head_pc", bus.out_pc, 64'h80000000);

        // Full queue with push and pop together: only the pop happens.
        drive(1'b1, 64'h80000010, 32'h00000013, 1'b1);
        step();
        chk("fullpp_count", 64'(count), 64'd3);
        chk("fullpp_head_pc", bus.out_pc, 64'h80000004);
        drive(1'b0, 64'h0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) step();
        chk("drain_count", 64'(count), 64'd0);

        // Decode of four reference instructions.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h2000 + 64'(4 * i), tbl[i], 1'b0);
            step();
        end
        drive(1'b0, 64'h0, 32'h0, 1'b0);
        chk("add_rs1", 64'(bus.out_rs1), 64'd10);
        chk("add_rs2", 64'(bus.out_rs2), 64'd11);
        chk("add_rd", 64'(bus.out_rd), 64'd10);
        chk("add_flags", 64'({bus.out_use_rs1, bus.out_use_rs2, bus.out_wen}), 64'b111);
        bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
        chk("sw_wen", 64'(bus.out_wen), 64'd0);
        chk("sw_rs1", 64'(bus.out_rs1), 64'd11);
        chk("sw_rs2", 64'(bus.out_rs2), 64'd10);
        bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
        chk("addi0_wen", 64'(bus.out_wen), 64'd0);
        chk("addi0_use_rs1", 64'(bus.out_use_rs1), 64'd1);
        chk("addi0_rs1", 64'(bus.out_rs1), 64'd0);
        bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
        chk("csr_addr", 64'(bus.out_csr_addr), 64'h300);
        chk("csr_wen", 64'(bus.out_wen), 64'd1);
        chk("csr_rd", 64'(bus.out_rd), 64'd5);
        bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
        chk("dec_empty", 64'(count), 64'd0);

        // Ten-instruction stream with random back-pressure across pointer wrap.
        pushed = 0;
        cyc    = 0;
        log_en = 1;
        while ((pushed < 10 || mq.size() != 0) && cyc < 300) begin
            drive(pushed < 10, 64'h1000 + 64'(4 * pushed), tbl[pushed % 8], 1'($urandom_range(0, 1)));
            accepted = bus.in_valid && (mq.size() < DEPTH);
            step();
            if (accepted) pushed++;
            cyc++;
        end
        drive(1'b0, 64'h0, 32'h0, 1'b0);
        log_en = 0;
        chk("stream_bound", 64'(cyc < 300), 64'd1);
        chk("stream_pops", 64'(pop_log.size()), 64'd10);
        for (int i = 0; i < pop_log.size(); i++)
            chk("stream_order", pop_log[i], 64'h1000 + 64'(4 * i));

        // Flush with push and pop requested in the same cycle.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h3000 + 64'(4 * i), tbl[i], 1'b0);
            step();
        end
        chk("preflush_count", 64'(count), 64'd3);
        flush = 1'b1;
        drive(1'b1, 64'h300C, tbl[3], 1'b1);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        flush = 1'b0;
        drive(1'b0, 64'h0, 32'h0, 1'b0);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        step();
        chk("postflush_count", 64'(count), 64'd0);

        // Reset mid-stream discards entries and the same-cycle push.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 64'h4000 + 64'(4 * i), tbl[i], 1'b0);
            step();
        end
        chk("prereset_count", 64'(count), 64'd2);
        reset = 1'b1;
        drive(1'b1, 64'h4008, tbl[2], 1'b1);
        step();
        reset = 1'b0;
        drive(1'b0, 64'h0, 32'h0, 1'b0);
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);

        // Reset and flush together behave as reset.
        drive(1'b1, 64'h5000, tbl[4], 1'b0);
        step();
        reset = 1'b1;
        flush = 1'b1;
        drive(1'b1, 64'h5004, tbl[5], 1'b1);
        step();
        reset = 1'b0;
        flush = 1'b0;
        drive(1'b0, 64'h0, 32'h0, 1'b0);
        chk("rstflush_count", 64'(count), 64'd0);
        chk("rstflush_out_valid", 64'(bus.out_valid), 64'd0);
        step();

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
